uart_csr_bridge: RTL and testbench
==================================

# uart_csr_bridge

Framed-command parser between the UART receiver/transmitter and the `csr` host bus. It consumes a byte stream and checks a CRC-8. It issues single-cycle CSR write/read strobes and returns an ACK, data or NAK frame to the UART transmitter. It is the only master of the CSR bus and the source of the `rx_crc_error` and `rx_illegal_cmd` events.

## Interface
- `ADDR_W`, default 8: CSR byte-address width; matches `csr`.
- `TIMEOUT_CYC`, default 100000: inter-byte timeout in clk cycles. Only used with `UART_BRIDGE_TIMEOUT_EN`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: received byte available.
- `rx_data` in 8: received byte.
- `rx_ready` out 1: bridge accepts the byte this cycle.
- `tx_valid` out 1: response byte valid.
- `tx_data` out 8: response byte.
- `tx_ready` in 1: transmitter accepts the byte.
- `crc_en` in 1: CRC check enable, from `csr.uart_crc_en`.
- `csr_wen`, `csr_ren` out 1: single-cycle strobes.
- `csr_addr` out ADDR_W: CSR byte address.
- `csr_wdata` out 32: write data.
- `csr_rdata` in 32: combinational read data, valid in the same cycle as `csr_ren`.
- `rx_crc_error`, `rx_illegal_cmd` out 1: single-cycle event pulses.

## Operation
- Request frame: CMD, ADDR, then D0..D3 (little-endian, write only), then CRC.
  - CMD 0x01 = write, 0x02 = read.
  - CRC-8: polynomial 0x07, init 0x00, MSB-first, no reflection. It covers CMD through the last data byte.
- States:
  - IDLE: wait for CMD.
  - ADDR: capture the address byte.
  - DATA: 2-bit count, four bytes, write only.
  - CRC: receive and check the CRC byte.
  - EXEC: one cycle.
  - RESP: send the response, with a byte counter.
- IDLE behaviour:
  - A legal CMD resets the CRC accumulator to 0x00, folds in CMD, and moves to ADDR.
  - An illegal CMD is dropped: `rx_illegal_cmd` pulses next cycle, the bridge stays in IDLE, and no response is sent.
- CRC state:
  - Mismatch with `crc_en`=1: `rx_crc_error` pulse, no CSR access, RESP sends NAK (0xEE).
  - With `crc_en`=0 the CRC byte is consumed and ignored.
- EXEC:
  - Write: `csr_wen`=1 with latched `csr_addr`/`csr_wdata`. Response is ACK (0xA1).
  - Read: `csr_ren`=1, and `csr_rdata` is captured into a 32-bit register that same cycle. Response is 0xA2, R0..R3 (LE), then CRC-8 over 0xA2..R3.
- RESP: each byte is held on `tx_data`, with `tx_valid`=1, until `tx_ready`. The last accepted byte returns the FSM to IDLE.
- `rx_ready`=1 in IDLE, ADDR, DATA and CRC; 0 in EXEC and RESP. No bytes are buffered.
- Unaligned addresses (`csr_addr[1:0]`≠0) are forwarded unchanged; `csr` flags them.

## Timing
- Reset values:
  - State IDLE; `rx_ready`=1.
  - `tx_valid`=0, `tx_data`=0x00.
  - `csr_wen`=`csr_ren`=0, `csr_addr`=0, `csr_wdata`=0.
  - Both error pulses 0; CRC accumulator 0x00.
- A byte transfers on a clk edge with `rx_valid`&`rx_ready`.
- Latency: CRC byte accepted on edge N. EXEC strobe is high during cycle N+1. The first response byte is valid from cycle N+2.
- Error pulses are registered and high exactly one cycle after the offending byte is accepted.
- `csr_addr`/`csr_wdata` stay stable from EXEC until the next frame's ADDR/DATA capture.
- `tx_valid` must not drop before `tx_ready`. `tx_data` changes only after an accepted transfer.
- `rst` mid-frame or mid-response: immediate return to IDLE, no strobe and no pulse. The partial response is abandoned.
- `crc_en` is sampled in the CRC state only.

## Configuration
- `UART_BRIDGE_TIMEOUT_EN` defined:
  - A 32-bit counter runs in ADDR, DATA and CRC, and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYC` the FSM returns to IDLE and `rx_illegal_cmd` pulses once. No response is sent.
- Undefined: no counter. A partial frame waits indefinitely.

## Structure
- Package `accel_uart_pkg`:
  - Command codes 0x01 and 0x02; response codes 0xA1, 0xA2 and 0xEE.
  - CRC polynomial 0x07.
  - State enum.
- Sub-module `uart_crc8`: combinational byte update (crc_in, byte → crc_out). Instantiated twice, once for the RX accumulator and once for the TX accumulator.

## Test plan
- Write frame 01 10 04 00 00 00 + valid CRC → `csr_wen` pulse with addr 0x10, wdata 0x00000004; TX 0xA1.
- Read frame 02 3C + CRC, with `csr_rdata`=0x00000302 during `csr_ren` → TX A2 02 03 00 00 + CRC-8 of those five bytes.
- Write with corrupted CRC, `crc_en`=1 → `rx_crc_error` one-cycle pulse, no `csr_wen`, TX 0xEE. Same frame with `crc_en`=0 → write executes, TX 0xA1.
- CMD 0x55 → one `rx_illegal_cmd` pulse, no TX. A following legal frame is parsed normally.
- `tx_ready` held low 10 cycles during a read response → `tx_valid`/`tx_data` stable and `rx_ready`=0 throughout. `rst` asserted mid-response → all outputs at reset values.
- With `UART_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYC`=20: send CMD 0x01, ADDR, then idle 20 cycles → `rx_illegal_cmd` pulse, back to IDLE, and the next byte is treated as CMD.

Source files
------------

// File: rtl/accel_uart_pkg.sv
// Shared constants and state encoding for the UART-to-CSR command bridge.
package accel_uart_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] RSP_ACK   = 8'hA1;
    localparam logic [7:0] RSP_READ  = 8'hA2;
    localparam logic [7:0] RSP_NAK   = 8'hEE;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CRC,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/uart_crc8.sv
// CRC-8 (poly 0x07, MSB-first, no reflection) update of an accumulator by one byte.
module uart_crc8
    import accel_uart_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_byte,
    output logic [7:0] o_crc
);

    always_comb begin
        // NOTE: blocking assignments chain the eight shift steps within one evaluation.
        o_crc = i_crc ^ i_byte;
        for (int i = 0; i < 8; i++) begin
            o_crc = o_crc[7] ? ((o_crc << 1) ^ CRC8_POLY) : (o_crc << 1);
        end
    end

endmodule

// File: rtl/uart_csr_bridge.sv
// Framed UART command parser driving single-cycle CSR strobes and returning ACK/data/NAK.
// Optional inter-byte timeout enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_csr_bridge
    import accel_uart_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    input  logic              crc_en,
    output logic              csr_wen,
    output logic              csr_ren,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [31:0]       csr_wdata,
    input  logic [31:0]       csr_rdata,
    output logic              rx_crc_error,
    output logic              rx_illegal_cmd
);

    state_t            r_state, w_next_state;
    logic              r_is_write, r_nak, r_tx_valid, r_crc_error, r_illegal;
    logic [1:0]        r_byte_cnt;
    logic [2:0]        r_tx_idx, r_tx_last;
    logic [7:0]        r_rx_crc, r_tx_crc, r_tx_data;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_rdata;
    logic              w_rx_fire, w_timeout;
    logic [7:0]        w_rx_crc_in, w_rx_crc_next, w_tx_crc_in, w_tx_crc_next, w_tx_byte;

    assign rx_ready       = (r_state == ST_IDLE) || (r_state == ST_ADDR) ||
                            (r_state == ST_DATA) || (r_state == ST_CRC);
    assign w_rx_fire      = rx_valid && rx_ready;
    assign csr_wen        = (r_state == ST_EXEC) && r_is_write && !r_nak;
    assign csr_ren        = (r_state == ST_EXEC) && !r_is_write && !r_nak;
    assign csr_addr       = r_addr;
    assign csr_wdata      = r_wdata;
    assign tx_valid       = r_tx_valid;
    assign tx_data        = r_tx_data;
    assign rx_crc_error   = r_crc_error;
    assign rx_illegal_cmd = r_illegal;

    // A new frame restarts the RX accumulator; the TX accumulator restarts on the 0xA2 header.
    assign w_rx_crc_in = (r_state == ST_IDLE) ? 8'h00 : r_rx_crc;
    assign w_tx_crc_in = (r_state == ST_EXEC) ? 8'h00 : r_tx_crc;
    assign w_tx_byte   = (r_state == ST_EXEC) ? RSP_READ :
                         (r_tx_idx == 3'd4)   ? r_tx_crc :
                         r_rdata[{r_tx_idx[1:0], 3'b000} +: 8];

    uart_crc8 u_rx_crc (.i_crc(w_rx_crc_in), .i_byte(rx_data),   .o_crc(w_rx_crc_next));
    uart_crc8 u_tx_crc (.i_crc(w_tx_crc_in), .i_byte(w_tx_byte), .o_crc(w_tx_crc_next));

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        w_counting;

    assign w_counting = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CRC);
    assign w_timeout  = w_counting && !w_rx_fire && (r_to_cnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (!w_counting || w_rx_fire || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end
`else
    // Without the timeout a partial frame waits indefinitely.
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves the next state unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_rx_fire && is_cmd(rx_data)) w_next_state = ST_ADDR;
            ST_ADDR: if (w_rx_fire) w_next_state = r_is_write ? ST_DATA : ST_CRC;
            ST_DATA: if (w_rx_fire && (r_byte_cnt == 2'd3)) w_next_state = ST_CRC;
            ST_CRC:  if (w_rx_fire) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: if (tx_ready && (r_tx_idx == r_tx_last)) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if (w_timeout) w_next_state = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_write  <= 1'b0;
            r_nak       <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_crc_error <= 1'b0;
            r_illegal   <= 1'b0;
            r_byte_cnt  <= 2'd0;
            r_tx_idx    <= 3'd0;
            r_tx_last   <= 3'd0;
            r_rx_crc    <= 8'h00;
            r_tx_crc    <= 8'h00;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            r_crc_error <= 1'b0;
            r_illegal   <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_rx_fire) begin
                    if (is_cmd(rx_data)) begin
                        r_rx_crc   <= w_rx_crc_next;
                        r_is_write <= (rx_data == CMD_WRITE);
                    end else begin
                        r_illegal <= 1'b1;
                    end
                end
                ST_ADDR: if (w_rx_fire) begin
                    r_addr     <= ADDR_W'(rx_data);
                    r_rx_crc   <= w_rx_crc_next;
                    r_byte_cnt <= 2'd0;
                end
                ST_DATA: if (w_rx_fire) begin
                    r_wdata[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                    r_rx_crc   <= w_rx_crc_next;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
                ST_CRC: if (w_rx_fire) begin
                    r_nak       <= crc_en && (rx_data != r_rx_crc);
                    r_crc_error <= crc_en && (rx_data != r_rx_crc);
                end
                ST_EXEC: begin
                    r_tx_valid <= 1'b1;
                    r_tx_idx   <= 3'd0;
                    if (r_nak) begin
                        r_tx_data <= RSP_NAK;
                        r_tx_last <= 3'd0;
                    end else if (r_is_write) begin
                        r_tx_data <= RSP_ACK;
                        r_tx_last <= 3'd0;
                    end else begin
                        r_tx_data <= RSP_READ;
                        r_tx_last <= 3'd5;
                        r_rdata   <= csr_rdata;
                        r_tx_crc  <= w_tx_crc_next;
                    end
                end
                ST_RESP: if (tx_ready) begin
                    if (r_tx_idx == r_tx_last) begin
                        r_tx_valid <= 1'b0;
                    end else begin
                        r_tx_idx  <= r_tx_idx + 3'd1;
                        r_tx_data <= w_tx_byte;
                        r_tx_crc  <= w_tx_crc_next;
                    end
                end
                default: ;
            endcase
            if (w_timeout) r_illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_csr_bridge.sv
// Self-checking bench for uart_csr_bridge: frame-level queue model compared every cycle,
// directed frames with hand-computed CRCs, then randomized traffic.
module tb_uart_csr_bridge;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TO_CYC = 20;
`else
    localparam int TO_CYC = 100000;
`endif

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst, rx_valid, rx_ready, tx_valid, tx_ready, crc_en;
    logic        csr_wen, csr_ren, rx_crc_error, rx_illegal_cmd;
    logic [7:0]  rx_data, tx_data, csr_addr;
    logic [31:0] csr_wdata, csr_rdata;

    uart_csr_bridge #(.ADDR_W(8), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .crc_en(crc_en),
        .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .rx_crc_error(rx_crc_error), .rx_illegal_cmd(rx_illegal_cmd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial textbook CRC-8: shift the message MSB-first through the 0x07 feedback.
    function automatic logic [7:0] crc8(input bq_t q);
        logic [7:0] c = 8'h00;
        foreach (q[k]) begin
            for (int b = 7; b >= 0; b--) begin
                logic fb;
                fb = c[7] ^ q[k][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    // ---------------- frame-level reference model ----------------
    bq_t         m_frame, m_resp, m_body;
    bit          m_exec = 0, m_exec_nak = 0, m_exec_write = 0, m_ready = 1, m_was_exec = 0, m_ok = 0;
    logic        m_wen = 0, m_ren = 0, m_err = 0, m_ill = 0;
    logic [7:0]  m_addr = 0;
    logic [31:0] m_wdata = 0;
    int          m_idle = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_frame.delete(); m_resp.delete();
            m_exec = 0; m_wen = 0; m_ren = 0; m_err = 0; m_ill = 0; m_idle = 0;
        end else begin
            m_ready    = !m_exec && (m_resp.size() == 0);
            m_was_exec = m_exec;
            if (m_resp.size() > 0 && tx_ready) void'(m_resp.pop_front());
            if (m_was_exec) begin
                if (m_exec_nak) m_resp.push_back(8'hEE);
                else if (m_exec_write) m_resp.push_back(8'hA1);
                else begin
                    m_resp.push_back(8'hA2);
                    for (int k = 0; k < 4; k++) m_resp.push_back(csr_rdata[8*k +: 8]);
                    m_resp.push_back(crc8(m_resp));
                end
            end
            m_exec = 0; m_wen = 0; m_ren = 0; m_err = 0; m_ill = 0;
            if (m_ready && rx_valid) begin
                m_idle = 0;
                if (m_frame.size() == 0 && rx_data != 8'h01 && rx_data != 8'h02) m_ill = 1;
                else m_frame.push_back(rx_data);
                if (m_frame.size() > 0 && m_frame.size() == ((m_frame[0] == 8'h01) ? 7 : 3)) begin
                    m_body       = m_frame[0:$-1];
                    m_ok         = !crc_en || (crc8(m_body) == m_frame[$]);
                    m_exec       = 1;
                    m_exec_nak   = !m_ok;
                    m_exec_write = (m_frame[0] == 8'h01);
                    m_err        = !m_ok;
                    m_wen        = m_ok && m_exec_write;
                    m_ren        = m_ok && !m_exec_write;
                    m_addr       = m_frame[1];
                    if (m_exec_write) m_wdata = {m_frame[5], m_frame[4], m_frame[3], m_frame[2]};
                    m_frame.delete();
                end
            end else if (m_frame.size() > 0) begin
`ifdef UART_BRIDGE_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO_CYC) begin
                    m_frame.delete();
                    m_ill  = 1;
                    m_idle = 0;
                end
`endif
            end
        end
    end

    // ---------------- per-cycle compare and event monitor ----------------
    bq_t         tx_log;
    int          wen_cnt = 0, ren_cnt = 0, err_cnt = 0, ill_cnt = 0;
    logic [7:0]  last_addr = 0;
    logic [31:0] last_wdata = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_rx_ready", rx_ready, 1);
            check("rst_tx_valid", tx_valid, 0);
            check("rst_tx_data", tx_data, 0);
            check("rst_strobes", {csr_wen, csr_ren, rx_crc_error, rx_illegal_cmd}, 0);
            check("rst_addr_wdata", csr_addr | csr_wdata, 0);
        end else begin
            check("rx_ready", rx_ready, !m_exec && (m_resp.size() == 0));
            check("tx_valid", tx_valid, m_resp.size() > 0);
            if (m_resp.size() > 0) check("tx_data", tx_data, m_resp[0]);
            check("csr_wen", csr_wen, m_wen);
            check("csr_ren", csr_ren, m_ren);
            if (m_wen || m_ren) check("csr_addr", csr_addr, m_addr);
            if (m_wen) check("csr_wdata", csr_wdata, m_wdata);
            check("rx_crc_error", rx_crc_error, m_err);
            check("rx_illegal_cmd", rx_illegal_cmd, m_ill);
            if (tx_valid && tx_ready) tx_log.push_back(tx_data);
            wen_cnt += int'(csr_wen);
            ren_cnt += int'(csr_ren);
            err_cnt += int'(rx_crc_error);
            ill_cnt += int'(rx_illegal_cmd);
            if (csr_wen) begin
                last_addr  = csr_addr;
                last_wdata = csr_wdata;
            end
        end
    end

    // ---------------- input drivers ----------------
    int          tx_mode = 2;     // 0 random, 1 held low, 2 held high
    int          crc_mode = 1;    // 0 off, 1 on, 2 random
    bit          rdata_random = 0;
    logic [31:0] rdata_fixed = 0;

    always @(posedge clk) begin
        #1;
        tx_ready  = (tx_mode == 0) ? ($urandom_range(0, 3) != 0) : (tx_mode == 2);
        crc_en    = (crc_mode == 2) ? 1'($urandom_range(0, 1)) : (crc_mode == 1);
        csr_rdata = rdata_random ? $urandom : rdata_fixed;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n   = 0;
        bit  acc = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!acc && n < 200) begin
            acc = rx_ready;
            tick();
            n++;
        end
        rx_valid = 1'b0;
        if (!acc) check("rx_accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input bq_t f, input int max_gap);
        foreach (f[i]) begin
            send_byte(f[i]);
            repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic drain();
        int n = 0;
        while (!(rx_ready && !tx_valid) && n < 500) begin
            tick();
            n++;
        end
        check("drain_idle", rx_ready && !tx_valid, 1);
    endtask

    task automatic expect_log(input string name, input bq_t exp);
        check({name, "_len"}, tx_log.size(), exp.size());
        foreach (exp[i]) if (i < tx_log.size()) check(name, tx_log[i], exp[i]);
        tx_log.delete();
    endtask

    bq_t wr_frame, rd_frame, bad_frame, rand_frame;
    bq_t exp_ack, exp_nak, exp_rd, pin_q;
    int  w0, r0, e0, i0, n;
    logic [7:0]  hold, b;
    logic [31:0] d;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        tx_ready = 1'b1; crc_en = 1'b1; csr_rdata = 32'h0;

        wr_frame = '{8'h01, 8'h10, 8'h04, 8'h00, 8'h00, 8'h00, 8'h43};
        rd_frame = '{8'h02, 8'h3C, 8'h9E};
        bad_frame = '{8'h01, 8'h10, 8'h04, 8'h00, 8'h00, 8'h00, 8'h44};
        exp_ack = '{8'hA1};
        exp_nak = '{8'hEE};
        exp_rd  = '{8'hA2, 8'h02, 8'h03, 8'h00, 8'h00, 8'hA6};

        // Hand-computed CRCs pin the model's CRC function.
        pin_q = wr_frame[0:5];  check("pin_crc_write", crc8(pin_q), 8'h43);
        pin_q = rd_frame[0:1];  check("pin_crc_read", crc8(pin_q), 8'h9E);
        pin_q = exp_rd[0:4];    check("pin_crc_resp", crc8(pin_q), 8'hA6);

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Write 0x00000004 to 0x10.
        tx_log.delete(); w0 = wen_cnt;
        send_frame(wr_frame, 0); drain();
        expect_log("wr_resp", exp_ack);
        check("wr_wen_count", wen_cnt - w0, 1);
        check("wr_addr", last_addr, 8'h10);
        check("wr_wdata", last_wdata, 32'h4);

        // Read 0x3C returning 0x00000302.
        rdata_fixed = 32'h0000_0302; r0 = ren_cnt;
        send_frame(rd_frame, 0); drain();
        expect_log("rd_resp", exp_rd);
        check("rd_ren_count", ren_cnt - r0, 1);

        // Corrupted CRC with and without checking.
        w0 = wen_cnt; e0 = err_cnt;
        send_frame(bad_frame, 0); drain();
        expect_log("crc_bad_resp", exp_nak);
        check("crc_bad_no_wen", wen_cnt - w0, 0);
        check("crc_bad_err_count", err_cnt - e0, 1);
        crc_mode = 0; tick();
        w0 = wen_cnt; e0 = err_cnt;
        send_frame(bad_frame, 0); drain();
        expect_log("crc_off_resp", exp_ack);
        check("crc_off_wen", wen_cnt - w0, 1);
        check("crc_off_no_err", err_cnt - e0, 0);
        crc_mode = 1; tick();

        // Illegal command, then a normal frame.
        i0 = ill_cnt;
        send_byte(8'h55); repeat (3) tick();
        check("ill_count", ill_cnt - i0, 1);
        check("ill_no_tx", tx_log.size(), 0);
        send_frame(wr_frame, 1); drain();
        expect_log("after_ill_resp", exp_ack);

        // Back-pressure during a read response, then reset mid-response.
        tx_mode = 1;
        send_frame(rd_frame, 0);
        n = 0;
        while (!tx_valid && n < 20) begin tick(); n++; end
        hold = tx_data;
        check("stall_first_byte", hold, 8'hA2);
        repeat (10) begin
            tick();
            check("stall_tx_valid", tx_valid, 1);
            check("stall_tx_data", tx_data, hold);
            check("stall_rx_ready", rx_ready, 0);
        end
        rst = 1'b1;
        #1;
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_rx_ready", rx_ready, 1);
        tick(); tick();
        rst = 1'b0; tx_mode = 2;
        tick();
        tx_log.delete();

`ifdef UART_BRIDGE_TIMEOUT_EN
        i0 = ill_cnt;
        send_byte(8'h01); send_byte(8'h20);
        repeat (TO_CYC + 2) tick();
        check("timeout_ill_count", ill_cnt - i0, 1);
        check("timeout_rx_ready", rx_ready, 1);
        send_frame(wr_frame, 0); drain();
        expect_log("after_timeout_resp", exp_ack);
`endif

        // Randomized traffic against the model.
        tx_mode = 0; crc_mode = 2; rdata_random = 1;
        for (int f = 0; f < 200; f++) begin
            rand_frame.delete();
            if ($urandom_range(0, 9) == 0) begin
                b = 8'($urandom);
                if (b == 8'h01 || b == 8'h02) b = 8'h55;
                rand_frame.push_back(b);
            end else begin
                rand_frame.push_back($urandom_range(0, 1) ? 8'h01 : 8'h02);
                rand_frame.push_back(8'($urandom));
                if (rand_frame[0] == 8'h01) begin
                    d = $urandom;
                    for (int k = 0; k < 4; k++) rand_frame.push_back(d[8*k +: 8]);
                end
                b = crc8(rand_frame);
                if ($urandom_range(0, 4) == 0) b = b ^ 8'($urandom_range(1, 255));
                rand_frame.push_back(b);
            end
            send_frame(rand_frame, 2);
        end
        drain();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
